// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared types for the RV32 control-path pipeline: forward-select encodings,
// the per-stage control record and the forward-select comparator.
// Register addresses are held at their widest legal width (5 bits). The top
// zero-extends narrower (RV32E) addresses into the record and truncates them
// on the way out.
package riscv_ctrl_pkg;

    localparam int REG_AW_MAX = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    // One pipeline stage. The opaque control bundle is carried beside this
    // record because its width is a parameter of the top.
    typedef struct packed {
        logic                  valid;
        logic                  rdwe;
        logic                  load;
        logic                  multi;
        logic [REG_AW_MAX-1:0] rs1;
        logic [REG_AW_MAX-1:0] rs2;
        logic [REG_AW_MAX-1:0] rd;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // Operand source for one Execute read port. M is checked first, so the
    // youngest producer wins. x0 never matches because rd must be non-zero.
    function automatic fwd_e fwd_sel(input stage_t m, input stage_t w,
                                     input logic [REG_AW_MAX-1:0] rs);
        if (m.valid && m.rdwe && (m.rd != '0) && (m.rd == rs))
            return FWD_M;
        if (w.valid && w.rdwe && (w.rd != '0) && (w.rd == rs))
            return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/riscv_ctrl_pipe_hazard.sv
// riscv_ctrl_hazard
// Purely combinational hazard unit. It produces the Decode stall and flush,
// the request to insert a bubble into Execute, and the Execute operand
// forward selects.
// Ports:
//   e_i, m_i, w_i    stage records from the pipeline registers
//   valid_d_i        Decode holds a real instruction
//   rs1_d_i, rs2_d_i Decode source registers (zero-extended)
//   redirect_e_i     branch/jump taken in Execute
//   busy_i           multi-cycle op is occupying Execute
//   stall_o          hold PC and the F/D register
//   flush_o          clear the F/D register
//   bubble_e_o       Execute takes a bubble instead of Decode (only
//                    meaningful when not busy)
//   fwd_a_o, fwd_b_o forward selects for the Execute operands
module riscv_ctrl_hazard
    import riscv_ctrl_pkg::*;
(
    input  stage_t                e_i,
    input  stage_t                m_i,
    input  stage_t                w_i,
    input  logic                  valid_d_i,
    input  logic [REG_AW_MAX-1:0] rs1_d_i,
    input  logic [REG_AW_MAX-1:0] rs2_d_i,
    input  logic                  redirect_e_i,
    input  logic                  busy_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  bubble_e_o,
    output fwd_e                  fwd_a_o,
    output fwd_e                  fwd_b_o
);

    logic load_use;
    logic redirect;

    assign load_use = e_i.valid && e_i.load && e_i.rdwe && (e_i.rd != '0) &&
                      valid_d_i && ((e_i.rd == rs1_d_i) || (e_i.rd == rs2_d_i));

    // A branch is never multi-cycle, so a redirect seen while busy is ignored.
    assign redirect = redirect_e_i && e_i.valid && !busy_i;

    // The redirect discards the Decode instruction, so a load-use hazard
    // against it is moot and must not hold the PC.
    assign flush_o    = redirect;
    assign stall_o    = busy_i || (load_use && !redirect);
    assign bubble_e_o = redirect || load_use;

    assign fwd_a_o = fwd_sel(m_i, w_i, e_i.rs1);
    assign fwd_b_o = fwd_sel(m_i, w_i, e_i.rs2);

    // Record fields that the hazard logic has no use for.
    logic unused_fields;
    assign unused_fields = ^{e_i.multi, m_i.load, m_i.multi, m_i.rs1, m_i.rs2,
                             w_i.load, w_i.multi, w_i.rs1, w_i.rs2};

endmodule

// File: rtl/riscv_ctrl_pipe.sv
// riscv_ctrl_pipe
// Control-path pipeline for the 5-stage RV32 core. It carries the decoded
// control bundle from Decode through Execute, Memory and Writeback. It handles
// load-use stalls, redirect flushes and multi-cycle Execute ops, and drives
// the Execute forward selects.
// Ports:
//   iclk, irst                  clock, asynchronous active-high reset
//   ivalid_d, ictrl_d, irdwe_d,
//   iload_d, imulti_d,
//   irs1_d, irs2_d, ird_d       Decode-stage instruction
//   iredirect_e                 taken branch/jump resolved in Execute
//   ostall_d, oflush_d          Decode hold / clear
//   obusy_e                     multi-cycle op in progress
//   ofwd_a_e, ofwd_b_e          forward selects (00 RF, 10 M, 01 W)
//   ovalid_*, octrl_*           stage valid and control bundles
//   ord_m, ord_w, ordwe_w       destination registers, regfile write enable
module riscv_ctrl_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 16,
    parameter int REG_AW  = 5,
    parameter int DIV_LAT = 8
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              ivalid_d,
    input  logic [CTRL_W-1:0] ictrl_d,
    input  logic              irdwe_d,
    input  logic              iload_d,
    input  logic              imulti_d,
    input  logic [REG_AW-1:0] irs1_d,
    input  logic [REG_AW-1:0] irs2_d,
    input  logic [REG_AW-1:0] ird_d,
    input  logic              iredirect_e,
    output logic              ostall_d,
    output logic              oflush_d,
    output logic              obusy_e,
    output logic [1:0]        ofwd_a_e,
    output logic [1:0]        ofwd_b_e,
    output logic              ovalid_e,
    output logic              ovalid_m,
    output logic              ovalid_w,
    output logic [CTRL_W-1:0] octrl_e,
    output logic [CTRL_W-1:0] octrl_m,
    output logic [CTRL_W-1:0] octrl_w,
    output logic [REG_AW-1:0] ord_m,
    output logic [REG_AW-1:0] ord_w,
    output logic              ordwe_w
);

    // The counter needs at least one bit even when every op is single-cycle.
    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    stage_t            e_q, e_d, m_q, m_d, w_q, w_d;
    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d, ctrl_m_q, ctrl_m_d, ctrl_w_q, ctrl_w_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    stage_t                d_rec;
    logic [REG_AW_MAX-1:0] rs1_d, rs2_d;
    logic                  busy;
    logic                  bubble_e;
    fwd_e                  fwd_a, fwd_b;

    assign busy  = (cnt_q != '0);
    assign rs1_d = REG_AW_MAX'(irs1_d);
    assign rs2_d = REG_AW_MAX'(irs2_d);

    riscv_ctrl_hazard u_hazard (
        .e_i          (e_q),
        .m_i          (m_q),
        .w_i          (w_q),
        .valid_d_i    (ivalid_d),
        .rs1_d_i      (rs1_d),
        .rs2_d_i      (rs2_d),
        .redirect_e_i (iredirect_e),
        .busy_i       (busy),
        .stall_o      (ostall_d),
        .flush_o      (oflush_d),
        .bubble_e_o   (bubble_e),
        .fwd_a_o      (fwd_a),
        .fwd_b_o      (fwd_b)
    );

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        d_rec = BUBBLE;
        if (ivalid_d) begin
            d_rec.valid = 1'b1;
            d_rec.rdwe  = irdwe_d;
            d_rec.load  = iload_d;
            d_rec.multi = imulti_d;
            d_rec.rs1   = rs1_d;
            d_rec.rs2   = rs2_d;
            d_rec.rd    = REG_AW_MAX'(ird_d);
        end

        e_d      = e_q;
        ctrl_e_d = ctrl_e_q;
        m_d      = e_q;
        ctrl_m_d = ctrl_e_q;
        w_d      = m_q;
        ctrl_w_d = ctrl_m_q;
        cnt_d    = cnt_q;

        if (busy) begin
            // E holds the multi-cycle op; M and W keep draining behind it.
            m_d      = BUBBLE;
            ctrl_m_d = '0;
            cnt_d    = cnt_q - CNT_W'(1);
        end else if (bubble_e) begin
            e_d      = BUBBLE;
            ctrl_e_d = '0;
            cnt_d    = '0;
        end else begin
            e_d      = d_rec;
            ctrl_e_d = ivalid_d ? ictrl_d : '0;
            // The op has one Execute cycle even without the counter, so
            // DIV_LAT-1 extra cycles are loaded.
            cnt_d    = (ivalid_d && imulti_d && (DIV_LAT > 1)) ? CNT_W'(DIV_LAT - 1) : '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            e_q      <= BUBBLE;
            m_q      <= BUBBLE;
            w_q      <= BUBBLE;
            ctrl_e_q <= '0;
            ctrl_m_q <= '0;
            ctrl_w_q <= '0;
            cnt_q    <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_q      <= w_d;
            ctrl_e_q <= ctrl_e_d;
            ctrl_m_q <= ctrl_m_d;
            ctrl_w_q <= ctrl_w_d;
            cnt_q    <= cnt_d;
        end
    end

    assign obusy_e  = busy;
    assign ofwd_a_e = fwd_a;
    assign ofwd_b_e = fwd_b;
    assign ovalid_e = e_q.valid;
    assign ovalid_m = m_q.valid;
    assign ovalid_w = w_q.valid;
    assign octrl_e  = ctrl_e_q;
    assign octrl_m  = ctrl_m_q;
    assign octrl_w  = ctrl_w_q;
    assign ord_m    = REG_AW'(m_q.rd);
    assign ord_w    = REG_AW'(w_q.rd);
    assign ordwe_w  = w_q.valid && w_q.rdwe;

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Self-checking bench for riscv_ctrl_pipe. A scoreboard queue holds each
// instruction expected at Writeback together with the cycle it must arrive.
// Directed checks cover stalls, flushes, forwarding, busy timing and reset.
module tb_riscv_ctrl_pipe;

    localparam int CTRL_W  = 16;
    localparam int REG_AW  = 5;
    localparam int DIV_LAT = 8;

    logic              iclk;
    logic              irst;
    logic              ivalid_d;
    logic [CTRL_W-1:0] ictrl_d;
    logic              irdwe_d;
    logic              iload_d;
    logic              imulti_d;
    logic [REG_AW-1:0] irs1_d, irs2_d, ird_d;
    logic              iredirect_e;
    logic              ostall_d, oflush_d, obusy_e;
    logic [1:0]        ofwd_a_e, ofwd_b_e;
    logic              ovalid_e, ovalid_m, ovalid_w;
    logic [CTRL_W-1:0] octrl_e, octrl_m, octrl_w;
    logic [REG_AW-1:0] ord_m, ord_w;
    logic              ordwe_w;

    riscv_ctrl_pipe #(
        .CTRL_W  (CTRL_W),
        .REG_AW  (REG_AW),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .iclk        (iclk),
        .irst        (irst),
        .ivalid_d    (ivalid_d),
        .ictrl_d     (ictrl_d),
        .irdwe_d     (irdwe_d),
        .iload_d     (iload_d),
        .imulti_d    (imulti_d),
        .irs1_d      (irs1_d),
        .irs2_d      (irs2_d),
        .ird_d       (ird_d),
        .iredirect_e (iredirect_e),
        .ostall_d    (ostall_d),
        .oflush_d    (oflush_d),
        .obusy_e     (obusy_e),
        .ofwd_a_e    (ofwd_a_e),
        .ofwd_b_e    (ofwd_b_e),
        .ovalid_e    (ovalid_e),
        .ovalid_m    (ovalid_m),
        .ovalid_w    (ovalid_w),
        .octrl_e     (octrl_e),
        .octrl_m     (octrl_m),
        .octrl_w     (octrl_w),
        .ord_m       (ord_m),
        .ord_w       (ord_w),
        .ordwe_w     (ordwe_w)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rd;
        logic              rdwe;
        int                wcyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic idle_d();
        ivalid_d = 1'b0;
        ictrl_d  = '0;
        irdwe_d  = 1'b0;
        iload_d  = 1'b0;
        imulti_d = 1'b0;
        irs1_d   = '0;
        irs2_d   = '0;
        ird_d    = '0;
    endtask

    task automatic set_d(input logic [CTRL_W-1:0] ctrl, input logic rdwe, input logic load,
                         input logic multi, input logic [REG_AW-1:0] rs1,
                         input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd);
        ivalid_d = 1'b1;
        ictrl_d  = ctrl;
        irdwe_d  = rdwe;
        iload_d  = load;
        imulti_d = multi;
        irs1_d   = rs1;
        irs2_d   = rs2;
        ird_d    = rd;
    endtask

    task automatic expect_w(input logic [CTRL_W-1:0] ctrl, input logic [REG_AW-1:0] rd,
                            input logic rdwe, input int wcyc);
        exp_t e;
        e.ctrl = ctrl;
        e.rd   = rd;
        e.rdwe = rdwe;
        e.wcyc = wcyc;
        exp_q.push_back(e);
    endtask

    // Writeback monitor: every valid W slot must match the head of the
    // scoreboard and arrive in exactly the predicted cycle.
    always @(negedge iclk) begin
        if (!irst) begin
            while (exp_q.size() > 0 && exp_q[0].wcyc < cyc) begin
                check("w_missing_cycle", 32'(cyc), 32'(exp_q[0].wcyc));
                void'(exp_q.pop_front());
            end
            if (ovalid_w) begin
                if (exp_q.size() == 0) begin
                    check("w_unexpected_valid", 32'(ovalid_w), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("w_cycle", 32'(cyc), 32'(e.wcyc));
                    check("w_ctrl", 32'(octrl_w), 32'(e.ctrl));
                    check("w_rd", 32'(ord_w), 32'(e.rd));
                    check("w_rdwe", 32'(ordwe_w), 32'(e.rdwe));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'({ovalid_e, ovalid_m, ovalid_w}), 32'(0));
        check({tag, "_hazard"}, 32'({ostall_d, oflush_d, obusy_e}), 32'(0));
        check({tag, "_fwd"}, 32'({ofwd_a_e, ofwd_b_e}), 32'(0));
        check({tag, "_ctrl"}, 32'(octrl_e | octrl_m | octrl_w), 32'(0));
        check({tag, "_rd"}, 32'({ord_m, ord_w, ordwe_w}), 32'(0));
    endtask

    // Counts busy/stall cycles and bubbles entering M until busy drops.
    task automatic run_busy(input string tag, input int e_cyc);
        int busy_n  = 0;
        int stall_n = 0;
        int mb_n    = 0;
        int n       = 0;
        #1;
        while (obusy_e && n < 4 * DIV_LAT) begin
            busy_n++;
            if (ostall_d) stall_n++;
            n++;
            tick();
            #1;
            if (!ovalid_m) mb_n++;
        end
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(DIV_LAT - 1));
        check({tag, "_stall_cycles"}, 32'(stall_n), 32'(DIV_LAT - 1));
        check({tag, "_m_bubbles"}, 32'(mb_n), 32'(DIV_LAT - 1));
        check({tag, "_e_occupancy"}, 32'(cyc - e_cyc), 32'(DIV_LAT - 1));
    endtask

    initial begin
        int c_div;

        irst        = 1'b1;
        iredirect_e = 1'b0;
        idle_d();
        repeat (2) @(posedge iclk);
        #1;
        check_all_zero("reset");
        irst = 1'b0;
        tick();

        // Straight line: no dependences, each reaches W three cycles later.
        for (int i = 0; i < 3; i++) begin
            set_d(CTRL_W'(16'h0100 + i), 1'b1, 1'b0, 1'b0, REG_AW'(10 + i),
                  REG_AW'(14 + i), REG_AW'(1 + i));
            expect_w(CTRL_W'(16'h0100 + i), REG_AW'(1 + i), 1'b1, cyc + 3);
            #1;
            check("line_stall", 32'(ostall_d), 32'(0));
            tick();
        end
        idle_d();
        repeat (4) begin
            tick();
            check("line_drain_stall", 32'(ostall_d), 32'(0));
        end

        // Forwarding: M, W and M-over-W priority; x0 never forwarded.
        set_d(16'h0200, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5);
        expect_w(16'h0200, 5'd5, 1'b1, cyc + 3);
        tick();
        set_d(16'h0201, 1'b1, 1'b0, 1'b0, 5'd5, 5'd3, 5'd8);
        expect_w(16'h0201, 5'd8, 1'b1, cyc + 3);
        tick();
        check("fwd_m_a", 32'(ofwd_a_e), 32'(2'b10));
        check("fwd_m_b", 32'(ofwd_b_e), 32'(2'b00));
        set_d(16'h0202, 1'b1, 1'b0, 1'b0, 5'd4, 5'd5, 5'd9);
        expect_w(16'h0202, 5'd9, 1'b1, cyc + 3);
        tick();
        check("fwd_w_a", 32'(ofwd_a_e), 32'(2'b00));
        check("fwd_w_b", 32'(ofwd_b_e), 32'(2'b01));
        set_d(16'h0203, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12);
        expect_w(16'h0203, 5'd12, 1'b1, cyc + 3);
        tick();
        set_d(16'h0204, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd12);
        expect_w(16'h0204, 5'd12, 1'b1, cyc + 3);
        tick();
        set_d(16'h0205, 1'b1, 1'b0, 1'b0, 5'd12, 5'd3, 5'd13);
        expect_w(16'h0205, 5'd13, 1'b1, cyc + 3);
        tick();
        check("fwd_prio_a", 32'(ofwd_a_e), 32'(2'b10));
        check("fwd_prio_b", 32'(ofwd_b_e), 32'(2'b00));
        set_d(16'h0206, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
        expect_w(16'h0206, 5'd0, 1'b1, cyc + 3);
        tick();
        set_d(16'h0207, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd14);
        expect_w(16'h0207, 5'd14, 1'b1, cyc + 3);
        tick();
        check("fwd_x0_m", 32'({ofwd_a_e, ofwd_b_e}), 32'(0));
        set_d(16'h0208, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd15);
        expect_w(16'h0208, 5'd15, 1'b1, cyc + 3);
        tick();
        check("fwd_x0_w", 32'({ofwd_a_e, ofwd_b_e}), 32'(0));
        idle_d();
        repeat (4) tick();

        // Load-use: one stall cycle, one bubble, then forwarding from W.
        set_d(16'h0300, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd6);
        expect_w(16'h0300, 5'd6, 1'b1, cyc + 3);
        tick();
        set_d(16'h0301, 1'b1, 1'b0, 1'b0, 5'd6, 5'd1, 5'd7);
        #1;
        check("lu_stall", 32'(ostall_d), 32'(1));
        check("lu_flush", 32'(oflush_d), 32'(0));
        tick();
        check("lu_stall_once", 32'(ostall_d), 32'(0));
        check("lu_e_bubble", 32'(ovalid_e), 32'(0));
        expect_w(16'h0301, 5'd7, 1'b1, cyc + 3);
        tick();
        check("lu_fwd_a", 32'(ofwd_a_e), 32'(2'b01));
        check("lu_fwd_b", 32'(ofwd_b_e), 32'(2'b00));
        idle_d();
        repeat (4) tick();

        // Multi-cycle divide: DIV_LAT-1 busy/stall cycles, successor enters
        // E DIV_LAT cycles after the divide.
        set_d(16'h0400, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd11);
        expect_w(16'h0400, 5'd11, 1'b1, cyc + DIV_LAT + 2);
        tick();
        c_div = cyc;
        set_d(16'h0401, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd12);
        run_busy("div", c_div);
        check("div_e_hold", 32'(octrl_e), 32'(16'h0400));
        check("div_release_stall", 32'(ostall_d), 32'(0));
        expect_w(16'h0401, 5'd12, 1'b1, cyc + 3);
        tick();
        check("div_next_e", 32'(octrl_e), 32'(16'h0401));
        check("div_next_gap", 32'(cyc - c_div), 32'(DIV_LAT));
        idle_d();
        repeat (4) tick();

        // Redirect with a load-use hazard pending: flush wins, no stall.
        set_d(16'h0500, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd6);
        expect_w(16'h0500, 5'd6, 1'b1, cyc + 3);
        tick();
        set_d(16'h0501, 1'b1, 1'b0, 1'b0, 5'd6, 5'd2, 5'd7);
        iredirect_e = 1'b1;
        #1;
        check("redir_flush", 32'(oflush_d), 32'(1));
        check("redir_stall", 32'(ostall_d), 32'(0));
        tick();
        iredirect_e = 1'b0;
        idle_d();
        #1;
        check("redir_e_bubble", 32'(ovalid_e), 32'(0));
        check("redir_m_keeps", 32'(octrl_m), 32'(16'h0500));
        check("redir_flush_drop", 32'(oflush_d), 32'(0));
        repeat (4) tick();

        // Reset at busy cycle 3 abandons the op; a new one starts clean.
        set_d(16'h0600, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd15);
        tick();
        set_d(16'h0601, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd16);
        tick();
        tick();
        check("pre_rst_busy", 32'(obusy_e), 32'(1));
        irst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        idle_d();
        irst = 1'b0;
        tick();
        set_d(16'h0602, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd17);
        expect_w(16'h0602, 5'd17, 1'b1, cyc + DIV_LAT + 2);
        tick();
        c_div = cyc;
        idle_d();
        run_busy("post_rst", c_div);
        check("post_rst_e", 32'(octrl_e), 32'(16'h0602));
        repeat (5) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
